// File: rtl/eth_send_gen.sv
// Runtime-configurable UDP/IPv4 frame generator on a 64-bit AXI4-Stream TX port (clk156 domain).
// The IPv4 header checksum is computed once per run; each frame carries a 32-bit sequence number.
module eth_send_gen #(
  parameter int unsigned MAX_FRAME_LEN = 1514,
  parameter int unsigned MIN_FRAME_LEN = 60,
  parameter logic [47:0] eth_dst       = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [47:0] eth_src       = 48'hBB_BB_BB_BB_BB_BB,
  parameter logic [31:0] ip_saddr      = 32'hC0A8_017A,
  parameter logic [31:0] ip_daddr      = 32'hC0A8_0185,
  parameter logic [15:0] udp_sport     = 16'h3776,
  parameter logic [15:0] udp_dport     = 16'h3776
) (
  input  logic        clk156,
  input  logic        reset,
  input  logic        cfg_start,
  input  logic        cfg_stop,
  input  logic [10:0] cfg_frame_len,
  input  logic [27:0] cfg_ifg,
  input  logic [31:0] cfg_count,
  output logic        busy,
  output logic [31:0] sent_cnt,
  input  logic        s_axis_tx_tready,
  output logic        s_axis_tx_tvalid,
  output logic [63:0] s_axis_tx_tdata,
  output logic [7:0]  s_axis_tx_tkeep,
  output logic        s_axis_tx_tlast,
  output logic        s_axis_tx_tuser
);

  localparam logic [10:0] MinLen = 11'(MIN_FRAME_LEN);
  localparam logic [10:0] MaxLen = 11'(MAX_FRAME_LEN);
  // Constant part of the header sum; only tot_len varies per run.
  localparam logic [19:0] CsumBase = 20'(16'h4500) + 20'(16'h4011)
                                   + 20'(ip_saddr[31:16]) + 20'(ip_saddr[15:0])
                                   + 20'(ip_daddr[31:16]) + 20'(ip_daddr[15:0]);

  typedef enum logic [1:0] {StIdle, StPrep, StSend, StIfg} state_e;

  state_e      state_q;
  logic [10:0] len_q;
  logic [27:0] ifg_q, ifg_cnt_q;
  logic [31:0] count_q, seq_q;
  logic [15:0] check_q;
  logic [19:0] sum_q;
  logic [16:0] fold_q;
  logic [1:0]  prep_q;
  logic [7:0]  beat_q;
  logic        stop_q;

  logic [10:0]  clamp_len, len_m1, tot_len, udp_len, byte_n;
  logic [7:0]   last_beat, last_keep, load_idx, load_keep;
  logic         acc, at_last, load_last;
  logic [367:0] hdr;
  logic [7:0]   hdr_b [46];
  logic [63:0]  load_data;

  assign s_axis_tx_tuser = 1'b0;

  always_comb begin
    clamp_len = cfg_frame_len;
    if (cfg_frame_len < MinLen) clamp_len = MinLen;
    else if (cfg_frame_len > MaxLen) clamp_len = MaxLen;

    len_m1    = len_q - 11'd1;
    tot_len   = len_q - 11'd14;
    udp_len   = len_q - 11'd34;
    last_beat = len_m1[10:3];
    last_keep = 8'hFF >> (3'd7 - len_m1[2:0]);
    acc       = s_axis_tx_tvalid && s_axis_tx_tready;
    at_last   = beat_q == last_beat;
    // Index of the beat to present next: successor mid-frame, otherwise beat 0.
    load_idx  = (state_q == StSend && !at_last) ? beat_q + 8'd1 : 8'd0;

    hdr = {eth_dst, eth_src, 16'h0800, 8'h45, 8'h00, 5'd0, tot_len, 32'd0, 8'd64, 8'd17,
           check_q, ip_saddr, ip_daddr, udp_sport, udp_dport, 5'd0, udp_len, 16'd0, seq_q};
    for (int k = 0; k < 46; k++) hdr_b[k] = hdr[367 - 8*k -: 8];

    byte_n    = '0;
    load_data = '0;
    for (int i = 0; i < 8; i++) begin
      byte_n = {load_idx, 3'(i)};
      if (byte_n < 11'd46) load_data[8*i +: 8] = hdr_b[byte_n[5:0]];
    end
    load_last = load_idx == last_beat;
    load_keep = load_last ? last_keep : 8'hFF;
  end

  always_ff @(posedge clk156) begin
    if (reset) begin
      state_q          <= StIdle;
      len_q            <= MinLen;
      ifg_q            <= '0;
      ifg_cnt_q        <= '0;
      count_q          <= '0;
      seq_q            <= '0;
      check_q          <= '0;
      sum_q            <= '0;
      fold_q           <= '0;
      prep_q           <= '0;
      beat_q           <= '0;
      stop_q           <= 1'b0;
      busy             <= 1'b0;
      sent_cnt         <= '0;
      s_axis_tx_tvalid <= 1'b0;
      s_axis_tx_tdata  <= '0;
      s_axis_tx_tkeep  <= '0;
      s_axis_tx_tlast  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cfg_start) begin
            len_q    <= clamp_len;
            ifg_q    <= cfg_ifg;
            count_q  <= cfg_count;
            sent_cnt <= '0;
            stop_q   <= 1'b0;
            prep_q   <= '0;
            busy     <= 1'b1;
            state_q  <= StPrep;
          end
        end
        StPrep: begin
          if (cfg_stop) begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end else begin
            prep_q <= prep_q + 2'd1;
            case (prep_q)
              2'd0: sum_q <= CsumBase + 20'(tot_len);
              2'd1: fold_q <= {1'b0, sum_q[15:0]} + {13'd0, sum_q[19:16]};
              default: begin
                check_q          <= ~(fold_q[15:0] + {15'd0, fold_q[16]});
                beat_q           <= load_idx;
                s_axis_tx_tvalid <= 1'b1;
                s_axis_tx_tdata  <= load_data;
                s_axis_tx_tkeep  <= load_keep;
                s_axis_tx_tlast  <= load_last;
                state_q          <= StSend;
              end
            endcase
          end
        end
        StSend: begin
          if (cfg_stop) stop_q <= 1'b1;
          if (acc) begin
            if (at_last) begin
              sent_cnt <= sent_cnt + 32'd1;
              seq_q    <= seq_q + 32'd1;
              if (stop_q || cfg_stop || (count_q != '0 && sent_cnt + 32'd1 == count_q)) begin
                s_axis_tx_tvalid <= 1'b0;
                s_axis_tx_tlast  <= 1'b0;
                stop_q           <= 1'b0;
                busy             <= 1'b0;
                state_q          <= StIdle;
              end else if (ifg_q != '0) begin
                s_axis_tx_tvalid <= 1'b0;
                s_axis_tx_tlast  <= 1'b0;
                ifg_cnt_q        <= ifg_q - 28'd1;
                state_q          <= StIfg;
              end else begin
                beat_q          <= load_idx;
                s_axis_tx_tdata <= load_data;
                s_axis_tx_tkeep <= load_keep;
                s_axis_tx_tlast <= load_last;
              end
            end else begin
              beat_q          <= load_idx;
              s_axis_tx_tdata <= load_data;
              s_axis_tx_tkeep <= load_keep;
              s_axis_tx_tlast <= load_last;
            end
          end
        end
        StIfg: begin
          if (cfg_stop) begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end else if (ifg_cnt_q == '0) begin
            beat_q           <= load_idx;
            s_axis_tx_tvalid <= 1'b1;
            s_axis_tx_tdata  <= load_data;
            s_axis_tx_tkeep  <= load_keep;
            s_axis_tx_tlast  <= load_last;
            state_q          <= StSend;
          end else begin
            ifg_cnt_q <= ifg_cnt_q - 28'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_send_gen.sv
// Scoreboard bench for eth_send_gen: stimulus queues expected beats, a negedge monitor checks them.
module tb_eth_send_gen;

  logic        clk156 = 1'b0;
  logic        reset;
  logic        cfg_start, cfg_stop;
  logic [10:0] cfg_frame_len;
  logic [27:0] cfg_ifg;
  logic [31:0] cfg_count;
  logic        busy;
  logic [31:0] sent_cnt;
  logic        tready = 1'b1;
  logic        tvalid, tlast, tuser;
  logic [63:0] tdata;
  logic [7:0]  tkeep;

  always #5 clk156 = ~clk156;

  eth_send_gen dut (
    .clk156          (clk156),
    .reset           (reset),
    .cfg_start       (cfg_start),
    .cfg_stop        (cfg_stop),
    .cfg_frame_len   (cfg_frame_len),
    .cfg_ifg         (cfg_ifg),
    .cfg_count       (cfg_count),
    .busy            (busy),
    .sent_cnt        (sent_cnt),
    .s_axis_tx_tready(tready),
    .s_axis_tx_tvalid(tvalid),
    .s_axis_tx_tdata (tdata),
    .s_axis_tx_tkeep (tkeep),
    .s_axis_tx_tlast (tlast),
    .s_axis_tx_tuser (tuser)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       mon_e;
  int          n_tests = 0;
  int          n_fail = 0;
  bit          rand_rdy = 1'b0;
  int          beat_in_frame = 0;
  int          frames_seen = 0;
  int          last_frame_beats = 0;
  int          gap = 0;
  int          last_gap = -1;
  bit          in_gap = 1'b0;
  logic [7:0]  last_keep = '0;
  logic [15:0] cap_check = '0;
  logic [31:0] seq_model;
  bit          prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic [7:0]  prev_keep;
  logic        prev_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Golden frame model: builds the byte image and queues the expected beats.
  task automatic push_frame(input int len, input logic [31:0] seq);
    logic [7:0]  fb [1520];
    logic [31:0] sum;
    beat_t       b;
    int          nb, cnt;
    foreach (fb[i]) fb[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      fb[i]     = 8'hFF;
      fb[6 + i] = 8'hBB;
    end
    fb[12] = 8'h08;
    fb[14] = 8'h45;
    fb[16] = 8'((len - 14) >> 8);
    fb[17] = 8'(len - 14);
    fb[22] = 8'h40;
    fb[23] = 8'h11;
    {fb[26], fb[27], fb[28], fb[29]} = 32'hC0A8017A;
    {fb[30], fb[31], fb[32], fb[33]} = 32'hC0A80185;
    {fb[34], fb[35], fb[36], fb[37]} = 32'h37763776;
    fb[38] = 8'((len - 34) >> 8);
    fb[39] = 8'(len - 34);
    {fb[42], fb[43], fb[44], fb[45]} = seq;
    sum = '0;
    for (int i = 14; i < 34; i += 2) sum += {16'h0, fb[i], fb[i + 1]};
    sum = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
    sum = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
    {fb[24], fb[25]} = ~sum[15:0];
    nb = (len + 7) / 8;
    for (int k = 0; k < nb; k++) begin
      for (int j = 0; j < 8; j++) b.data[8*j +: 8] = fb[8*k + j];
      cnt    = len - 8*k;
      b.keep = (cnt >= 8) ? 8'hFF : 8'((1 << cnt) - 1);
      b.last = (k == nb - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic start_run(input logic [10:0] len, input logic [27:0] ifg, input logic [31:0] cnt);
    @(posedge clk156); #1;
    cfg_frame_len = len;
    cfg_ifg       = ifg;
    cfg_count     = cnt;
    cfg_start     = 1'b1;
    @(posedge clk156); #1;
    cfg_start     = 1'b0;
    // Scramble the config inputs: the run must use the latched values.
    cfg_frame_len = 11'h7FF;
    cfg_ifg       = '1;
    cfg_count     = 32'd7;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      @(posedge clk156); #1;
    end
    chk("busy_falls", 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk156); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk156);
    #1;
    exp_q.delete();
    seq_model = '0;
    reset = 1'b0;
  endtask

  always @(posedge clk156) begin
    #1;
    tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk156) begin
    if (reset) begin
      beat_in_frame = 0;
      prev_stall    = 1'b0;
      in_gap        = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_ctrl", 64'({tvalid, tlast, tkeep}), 64'({1'b1, prev_last, prev_keep}));
        chk("hold_data", tdata, prev_data);
      end
      if (in_gap) begin
        if (tvalid) begin
          last_gap = gap;
          in_gap   = 1'b0;
        end else begin
          gap++;
        end
      end
      if (tvalid && tready) begin
        chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("tdata", tdata, mon_e.data);
          chk("tkeep", 64'(tkeep), 64'(mon_e.keep));
          chk("tlast", 64'(tlast), 64'(mon_e.last));
        end
        if (beat_in_frame == 3) cap_check = {tdata[7:0], tdata[15:8]};
        if (tlast) begin
          last_frame_beats = beat_in_frame + 1;
          last_keep        = tkeep;
          frames_seen++;
          beat_in_frame    = 0;
          in_gap           = 1'b1;
          gap              = 0;
        end else begin
          beat_in_frame++;
        end
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_keep  = tkeep;
      prev_last  = tlast;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, tv_cnt;
    bit found;
    reset         = 1'b1;
    cfg_start     = 1'b0;
    cfg_stop      = 1'b0;
    cfg_frame_len = '0;
    cfg_ifg       = '0;
    cfg_count     = '0;
    seq_model     = '0;
    repeat (3) @(posedge clk156);
    #1;
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tlast", 64'(tlast), 64'd0);
    chk("rst_tkeep", 64'(tkeep), 64'd0);
    chk("rst_tdata", tdata, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sent_cnt", 64'(sent_cnt), 64'd0);
    chk("tuser_zero", 64'(tuser), 64'd0);
    reset = 1'b0;

    // len 60, single frame
    push_frame(60, seq_model);
    seq_model++;
    start_run(11'd60, 28'd0, 32'd1);
    chk("t1_busy_high", 64'(busy), 64'd1);
    wait_idle(1000);
    chk("t1_sent_cnt", 64'(sent_cnt), 64'd1);
    chk("t1_beats", 64'(last_frame_beats), 64'd8);
    chk("t1_last_keep", 64'(last_keep), 64'h0F);
    chk("t1_ip_check", 64'(cap_check), 64'hF66F);
    chk("t1_drained", 64'(exp_q.size()), 64'd0);

    // len 1514, two frames, ifg 10, sequence restarts from reset
    do_reset();
    push_frame(1514, 32'd0);
    push_frame(1514, 32'd1);
    seq_model = 32'd2;
    last_gap  = -1;
    start_run(11'd1514, 28'd10, 32'd2);
    wait_idle(2000);
    chk("t2_sent_cnt", 64'(sent_cnt), 64'd2);
    chk("t2_beats", 64'(last_frame_beats), 64'd190);
    chk("t2_last_keep", 64'(last_keep), 64'h03);
    chk("t2_ip_check", 64'(cap_check), 64'hF0C1);
    chk("t2_ifg_gap", 64'(last_gap), 64'd10);
    chk("t2_drained", 64'(exp_q.size()), 64'd0);

    // len 64 under random backpressure
    push_frame(64, seq_model);
    seq_model++;
    rand_rdy = 1'b1;
    start_run(11'd64, 28'd0, 32'd1);
    wait_idle(1000);
    rand_rdy = 1'b0;
    chk("t3_sent_cnt", 64'(sent_cnt), 64'd1);
    chk("t3_beats", 64'(last_frame_beats), 64'd8);
    chk("t3_last_keep", 64'(last_keep), 64'hFF);
    chk("t3_drained", 64'(exp_q.size()), 64'd0);

    // Length clamping
    push_frame(60, seq_model);
    seq_model++;
    start_run(11'd20, 28'd0, 32'd1);
    wait_idle(1000);
    chk("t4_clamp_lo_beats", 64'(last_frame_beats), 64'd8);
    push_frame(1514, seq_model);
    seq_model++;
    start_run(11'd2000, 28'd0, 32'd1);
    wait_idle(1000);
    chk("t4_clamp_hi_beats", 64'(last_frame_beats), 64'd190);
    chk("t4_drained", 64'(exp_q.size()), 64'd0);

    // Unlimited run stopped during frame 5
    for (int f = 0; f < 5; f++) begin
      push_frame(60, seq_model);
      seq_model++;
    end
    base  = frames_seen;
    found = 1'b0;
    start_run(11'd60, 28'd0, 32'd0);
    for (int i = 0; i < 200; i++) begin
      if (frames_seen - base == 4 && beat_in_frame == 3) begin
        found = 1'b1;
        break;
      end
      @(posedge clk156); #1;
    end
    chk("t5_stop_point", 64'(found), 64'd1);
    cfg_stop = 1'b1;
    @(posedge clk156); #1;
    cfg_stop = 1'b0;
    wait_idle(200);
    chk("t5_sent_cnt", 64'(sent_cnt), 64'd5);
    chk("t5_frames", 64'(frames_seen - base), 64'd5);
    chk("t5_no_bubble", 64'(last_gap), 64'd0);
    chk("t5_drained", 64'(exp_q.size()), 64'd0);
    tv_cnt = 0;
    repeat (20) begin
      @(posedge clk156); #1;
      if (tvalid) tv_cnt++;
    end
    chk("t5_no_tvalid_after", 64'(tv_cnt), 64'd0);

    // Reset mid-frame, then a clean restart with sequence 0
    push_frame(60, seq_model);
    found = 1'b0;
    start_run(11'd60, 28'd0, 32'd1);
    for (int i = 0; i < 50; i++) begin
      if (beat_in_frame == 4) begin
        found = 1'b1;
        break;
      end
      @(posedge clk156); #1;
    end
    chk("t6_reset_point", 64'(found), 64'd1);
    reset = 1'b1;
    @(posedge clk156); #1;
    chk("t6_tvalid_low", 64'(tvalid), 64'd0);
    chk("t6_busy_low", 64'(busy), 64'd0);
    chk("t6_sent_cnt", 64'(sent_cnt), 64'd0);
    exp_q.delete();
    seq_model = '0;
    reset = 1'b0;
    push_frame(60, seq_model);
    seq_model++;
    start_run(11'd60, 28'd0, 32'd1);
    wait_idle(1000);
    chk("t6_restart_sent", 64'(sent_cnt), 64'd1);
    chk("t6_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
